// File: rtl/aip_cfg_reg_bank_pkg.sv
// Shared register-map constants for the AIP config register bank.
// Host-side drivers and benches use these constants too.
package aip_cfg_reg_bank_pkg;

    localparam int CTRL_IDX    = 0;
    localparam int START_BIT   = 0;
    localparam int INT_EN_BIT  = 1;
    localparam int INT_CLR_BIT = 2;
    localparam int DONE_BIT    = 0;
    localparam int BUSY_BIT    = 1;

    // STATUS always sits at the last register index.
    function automatic int status_idx(input int selbits);
        return (1 << selbits) - 1;
    endfunction

endpackage

// File: rtl/aip_cfg_reg_bank_mux.sv
// Parametric readback mux.
// Selects one DATAWIDTH slice out of a packed register bus.
module aipParametricMux #(
    parameter int DATAWIDTH = 32,
    parameter int SELBITS   = 2
) (
    input  logic [(2**SELBITS)*DATAWIDTH-1:0] data_in,
    input  logic [SELBITS-1:0]                sel,
    output logic [DATAWIDTH-1:0]              data_out
);

    assign data_out = data_in[DATAWIDTH*sel +: DATAWIDTH];

endmodule

// File: rtl/aip_cfg_reg_bank.sv
// AIP host register bank: RW config registers, CTRL start/int handling,
// read-only STATUS, and a registered read port through the readback mux.
module aip_cfg_reg_bank
    import aip_cfg_reg_bank_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int SELBITS   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [SELBITS-1:0]                wr_addr,
    input  logic [DATAWIDTH-1:0]              wr_data,
    input  logic                              rd_en,
    input  logic [SELBITS-1:0]                rd_addr,
    output logic [DATAWIDTH-1:0]              rd_data,
    output logic                              rd_valid,
    input  logic                              done_in,
    input  logic [DATAWIDTH-3:0]              status_in,
    output logic                              start_o,
    output logic                              irq_o,
    output logic [(2**SELBITS)*DATAWIDTH-1:0] cfg_regs_o
);

    localparam int NUM_REGS   = 2**SELBITS;
    localparam int STATUS_IDX = status_idx(SELBITS);

    // Writable registers only; STATUS is assembled from live state.
    logic [NUM_REGS-2:0][DATAWIDTH-1:0] rw_q, rw_d;
    logic [DATAWIDTH-3:0]               status_q;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               start_q, start_d;
    logic                               irq_q, irq_d;
    logic                               rd_valid_q, rd_valid_d;
    logic [DATAWIDTH-1:0]               rd_data_q, rd_data_d;
    logic [DATAWIDTH-1:0]               mux_out;
    logic                               ctrl_wr, start_wr, clr_wr;

    always_comb begin
        ctrl_wr  = wr_en && (wr_addr == SELBITS'(CTRL_IDX));
        start_wr = ctrl_wr && wr_data[START_BIT];
        clr_wr   = ctrl_wr && wr_data[INT_CLR_BIT];

        rw_d = rw_q;
        for (int i = 0; i < STATUS_IDX; i++) begin
            if (wr_en && (wr_addr == SELBITS'(i))) rw_d[i] = wr_data;
        end
        // START and INT_CLR are action bits and always read back as 0.
        rw_d[CTRL_IDX][START_BIT]   = 1'b0;
        rw_d[CTRL_IDX][INT_CLR_BIT] = 1'b0;

        // A START restarts the core even if it completes this same cycle.
        busy_d = start_wr ? 1'b1 : (done_in ? 1'b0 : busy_q);
        // Completion beats both clear sources (START and INT_CLR).
        done_d = done_in | (done_q & ~start_wr & ~clr_wr);

        start_d    = start_wr;
        irq_d      = done_q & rw_q[CTRL_IDX][INT_EN_BIT];
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? mux_out : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q       <= '0;
            status_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rw_q       <= rw_d;
            status_q   <= status_in;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign cfg_regs_o = {status_q, busy_q, done_q, rw_q};

    aipParametricMux #(
        .DATAWIDTH(DATAWIDTH),
        .SELBITS  (SELBITS)
    ) u_rd_mux (
        .data_in (cfg_regs_o),
        .sel     (rd_addr),
        .data_out(mux_out)
    );

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign start_o  = start_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_aip_cfg_reg_bank.sv
// Bench for aip_cfg_reg_bank: directed register-map scenarios followed by
// random traffic, all checked against a register-level reference model.
module tb_aip_cfg_reg_bank;
    import aip_cfg_reg_bank_pkg::*;

    localparam int DW = 32;
    localparam int SB = 2;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en, rd_en, done_in;
    logic [SB-1:0]   wr_addr, rd_addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic            rd_valid, start_o, irq_o;
    logic [DW-3:0]   status_in;
    logic [NR*DW-1:0] cfg_regs_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_rw [NR-1];
    logic [DW-3:0] m_stat;
    logic          m_busy, m_done, m_start, m_irq, m_rdv;
    logic [DW-1:0] m_rd;

    aip_cfg_reg_bank #(.DATAWIDTH(DW), .SELBITS(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .done_in(done_in), .status_in(status_in),
        .start_o(start_o), .irq_o(irq_o), .cfg_regs_o(cfg_regs_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] m_reg(input int a);
        if (a == status_idx(SB)) return {m_stat, m_busy, m_done};
        return m_rw[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR-1; i++) m_rw[i] = '0;
        m_stat = '0; m_busy = 0; m_done = 0; m_start = 0; m_irq = 0;
        m_rdv = 0; m_rd = '0;
    endtask

    // Applies one clock edge's worth of host/core activity to the model.
    task automatic m_edge();
        logic st, clr;
        logic [DW-1:0] n_rd;
        n_rd  = rd_en ? m_reg(int'(rd_addr)) : m_rd;
        st    = wr_en && (int'(wr_addr) == CTRL_IDX) && wr_data[START_BIT];
        clr   = wr_en && (int'(wr_addr) == CTRL_IDX) && wr_data[INT_CLR_BIT];
        m_irq = m_done & m_rw[CTRL_IDX][INT_EN_BIT];
        if (st) m_busy = 1;
        else if (done_in) m_busy = 0;
        if (done_in) m_done = 1;
        else if (st || clr) m_done = 0;
        m_start = st;
        if (wr_en && int'(wr_addr) != status_idx(SB)) begin
            m_rw[wr_addr] = wr_data;
            if (int'(wr_addr) == CTRL_IDX) begin
                m_rw[CTRL_IDX][START_BIT]   = 1'b0;
                m_rw[CTRL_IDX][INT_CLR_BIT] = 1'b0;
            end
        end
        m_stat = status_in;
        m_rdv  = rd_en;
        m_rd   = n_rd;
    endtask

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rd_valid"}, NR*DW'(rd_valid), NR*DW'(m_rdv));
        chk({tag, ".rd_data"},  NR*DW'(rd_data),  NR*DW'(m_rd));
        chk({tag, ".start_o"},  NR*DW'(start_o),  NR*DW'(m_start));
        chk({tag, ".irq_o"},    NR*DW'(irq_o),    NR*DW'(m_irq));
        chk({tag, ".cfg_regs"}, cfg_regs_o, {m_reg(3), m_reg(2), m_reg(1), m_reg(0)});
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cyc(input string tag, input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic re, input int ra, input logic di);
        wr_en = we; wr_addr = SB'(wa); wr_data = wd;
        rd_en = re; rd_addr = SB'(ra); done_in = di;
        status_in = DW'($urandom) >> 2;
        @(posedge clk);
        m_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; wr_en = 0; rd_en = 0; done_in = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; status_in = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk); rst_n = 1;

        for (int a = 0; a < NR; a++) cyc("rd_after_reset", 0, 0, '0, 1, a, 0);
        idle("idle0");

        cyc("wr1", 1, 1, 32'hDEADBEEF, 0, 0, 0);
        cyc("wr2", 1, 2, 32'h12345678, 1, 1, 0);
        chk("rd_addr1_const", NR*DW'(rd_data), NR*DW'(32'hDEADBEEF));
        chk("cfg_slice1", NR*DW'(cfg_regs_o[63:32]), NR*DW'(32'hDEADBEEF));
        cyc("rd2", 0, 0, '0, 1, 2, 0);
        chk("rd_addr2_const", NR*DW'(rd_data), NR*DW'(32'h12345678));
        cyc("wr_status", 1, 3, 32'hFFFFFFFF, 0, 0, 0);
        cyc("rd_status", 0, 0, '0, 1, 3, 0);
        chk("status_ro", NR*DW'(rd_data[1:0]), NR*DW'(2'b00));

        cyc("start", 1, CTRL_IDX, 32'h3, 0, 0, 0);
        chk("start_pulse", NR*DW'(start_o), NR*DW'(1));
        cyc("rd_busy", 0, 0, '0, 1, 3, 0);
        chk("start_once", NR*DW'(start_o), NR*DW'(0));
        chk("busy_status", NR*DW'(rd_data[1:0]), NR*DW'(2'b10));
        cyc("done", 0, 0, '0, 0, 0, 1);
        cyc("rd_done", 0, 0, '0, 1, 3, 0);
        chk("done_status", NR*DW'(rd_data[1:0]), NR*DW'(2'b01));
        chk("irq_set", NR*DW'(irq_o), NR*DW'(1));

        cyc("int_clr", 1, CTRL_IDX, 32'h6, 0, 0, 0);
        idle("irq_drop");
        chk("irq_cleared", NR*DW'(irq_o), NR*DW'(0));
        cyc("done2", 0, 0, '0, 0, 0, 1);
        cyc("clr_vs_done", 1, CTRL_IDX, 32'h6, 0, 0, 1);
        chk("done_wins", NR*DW'(cfg_regs_o[96]), NR*DW'(1));
        idle("idle1");

        cyc("start_vs_done", 1, CTRL_IDX, 32'h3, 0, 0, 1);
        chk("busy_and_done", NR*DW'(cfg_regs_o[97:96]), NR*DW'(2'b11));
        cyc("restart", 1, CTRL_IDX, 32'h3, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle while busy.
        rst_n = 0;
        #2;
        m_reset();
        chk_all("async_reset");
        @(negedge clk); rst_n = 1;
        idle("post_reset");
        chk("no_start_on_release", NR*DW'(start_o), NR*DW'(0));

        cyc("rewr2", 1, 2, 32'h12345678, 0, 0, 0);
        cyc("rbw", 1, 2, 32'hA5A5A5A5, 1, 2, 0);
        chk("rbw_old", NR*DW'(rd_data), NR*DW'(32'h12345678));
        cyc("rbw_new", 0, 0, '0, 1, 2, 0);
        chk("rbw_new_const", NR*DW'(rd_data), NR*DW'(32'hA5A5A5A5));

        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[2:0] = 3'($urandom);
            cyc("random", 1'($urandom), int'($urandom_range(0, NR-1)), d,
                1'($urandom), int'($urandom_range(0, NR-1)), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
